// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: loads a parallel word into univ_shift_reg and shifts it out serially.
// Define PARITY_EN to append an even-parity bit period after the data bits.
`default_nettype none

module shift_seq_ctrl #(
  parameter int N             = 8,
  parameter int TICKS_PER_BIT = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tx_start,
  input  logic [N-1:0] din,
  input  logic         msb_first,
  input  logic [N-1:0] q,
  output logic [1:0]   ctrl,
  output logic [N-1:0] d,
  output logic         sout,
  output logic         busy,
  output logic         tx_done_tick
);

  localparam int BW = $clog2(N);
  localparam int TW = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BIT_LAST  = BW'(N - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BIT - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_SHIFT  = 3'd2;
  localparam logic [2:0] ST_DONE   = 3'd3;
`ifdef PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd4;
`endif

  localparam logic [1:0] CTRL_HOLD  = 2'b00;
  localparam logic [1:0] CTRL_LEFT  = 2'b01;
  localparam logic [1:0] CTRL_RIGHT = 2'b10;
  localparam logic [1:0] CTRL_LOAD  = 2'b11;

  logic [2:0]    state_q, state_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [TW-1:0] tick_q, tick_d;
  logic          dir_q, dir_d;
  logic [N-1:0]  word_q, word_d;
  logic          tick_last;
  logic          unused_q_bits;

  assign tick_last = (tick_q == TICK_LAST);
  // Only the end bits of q feed sout; the rest is deliberately ignored.
  assign unused_q_bits = ^q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      bit_q   <= '0;
      tick_q  <= '0;
      dir_q   <= 1'b1;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      tick_q  <= tick_d;
      dir_q   <= dir_d;
      word_q  <= word_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    tick_d  = tick_q;
    dir_d   = dir_q;
    word_d  = word_q;
    case (state_q)
      ST_IDLE: begin
        if (tx_start) begin
          word_d  = din;
          dir_d   = msb_first;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        bit_d   = '0;
        tick_d  = '0;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (tick_last) begin
          tick_d = '0;
          if (bit_q == BIT_LAST) begin
            bit_d = '0;
`ifdef PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_DONE;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
`ifdef PARITY_EN
      ST_PARITY: begin
        if (tick_last) begin
          tick_d  = '0;
          state_d = ST_DONE;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ctrl         = CTRL_HOLD;
    d            = '0;
    sout         = 1'b1;
    busy         = 1'b0;
    tx_done_tick = 1'b0;
    case (state_q)
      ST_LOAD: begin
        ctrl = CTRL_LOAD;
        d    = word_q;
        busy = 1'b1;
      end
      ST_SHIFT: begin
        busy = 1'b1;
        sout = dir_q ? q[N-1] : q[0];
        // Advance the register only when the current bit period ends.
        if (tick_last) ctrl = dir_q ? CTRL_LEFT : CTRL_RIGHT;
      end
`ifdef PARITY_EN
      ST_PARITY: begin
        busy = 1'b1;
        sout = ^word_q;
      end
`endif
      ST_DONE: begin
        busy         = 1'b1;
        tx_done_tick = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl driving a behavioural univ_shift_reg, TPB=1 and TPB=4 instances.
`default_nettype none

module tb_shift_seq_ctrl;

  localparam int N = 8;

  typedef struct packed {
    logic [1:0] ctrl;
    logic       sout;
    logic       busy;
    logic       done;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic         tx_start [2];
  logic [N-1:0] din      [2];
  logic         msb_first[2];
  logic [N-1:0] q        [2];
  logic [1:0]   ctrl     [2];
  logic [N-1:0] d        [2];
  logic         sout     [2];
  logic         busy     [2];
  logic         done     [2];

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  int   n_cmp = 0;
  int   n_err = 0;

  shift_seq_ctrl #(.N(N), .TICKS_PER_BIT(1)) u_dut0 (
    .clk(clk), .reset(reset), .tx_start(tx_start[0]), .din(din[0]),
    .msb_first(msb_first[0]), .q(q[0]), .ctrl(ctrl[0]), .d(d[0]),
    .sout(sout[0]), .busy(busy[0]), .tx_done_tick(done[0])
  );

  shift_seq_ctrl #(.N(N), .TICKS_PER_BIT(4)) u_dut1 (
    .clk(clk), .reset(reset), .tx_start(tx_start[1]), .din(din[1]),
    .msb_first(msb_first[1]), .q(q[1]), .ctrl(ctrl[1]), .d(d[1]),
    .sout(sout[1]), .busy(busy[1]), .tx_done_tick(done[1])
  );

  // Behavioural universal shift register: 00 hold, 01 left, 10 right, 11 load.
  always @(posedge clk or posedge reset) begin
    for (int u = 0; u < 2; u++) begin
      if (reset) q[u] <= '0;
      else case (ctrl[u])
        2'b01:   q[u] <= {q[u][N-2:0], d[u][0]};
        2'b10:   q[u] <= {d[u][N-1], q[u][N-1:1]};
        2'b11:   q[u] <= d[u];
        default: q[u] <= q[u];
      endcase
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q0.size() > 0) begin
      e = exp_q0.pop_front();
      chk("dut0 {ctrl,sout,busy,done}", {3'b0, ctrl[0], sout[0], busy[0], done[0]}, {3'b0, e});
    end
    if (exp_q1.size() > 0) begin
      e = exp_q1.pop_front();
      chk("dut1 {ctrl,sout,busy,done}", {3'b0, ctrl[1], sout[1], busy[1], done[1]}, {3'b0, e});
    end
  end

  task automatic push(input int u, input exp_t e);
    if (u == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  // Pushes the expected per-cycle trace of one frame (cycles 0..limit, limit<0 = whole
  // frame plus two idle cycles), then pulses tx_start for cycle 0.
  task automatic start_frame(input int u, input logic [N-1:0] w, input logic msb,
                             input int tpb, input int limit);
    int   cyc;
    logic b;
    cyc = 0;
    @(posedge clk); #2;
    tx_start[u] = 1'b1; din[u] = w; msb_first[u] = msb;
    push(u, '{2'b00, 1'b1, 1'b0, 1'b0});
    cyc++;
    if (limit < 0 || cyc <= limit) push(u, '{2'b11, 1'b1, 1'b1, 1'b0});
    cyc++;
    for (int i = 0; i < N; i++) begin
      b = msb ? w[N-1-i] : w[i];
      for (int t = 0; t < tpb; t++) begin
        if (limit < 0 || cyc <= limit)
          push(u, '{(t == tpb-1) ? (msb ? 2'b01 : 2'b10) : 2'b00, b, 1'b1, 1'b0});
        cyc++;
      end
    end
`ifdef PARITY_EN
    for (int t = 0; t < tpb; t++) begin
      if (limit < 0 || cyc <= limit) push(u, '{2'b00, ^w, 1'b1, 1'b0});
      cyc++;
    end
`endif
    if (limit < 0) begin
      push(u, '{2'b00, 1'b1, 1'b1, 1'b1});
      push(u, '{2'b00, 1'b1, 1'b0, 1'b0});
      push(u, '{2'b00, 1'b1, 1'b0, 1'b0});
    end
    @(posedge clk); #2;
    tx_start[u] = 1'b0;
  endtask

  task automatic drain(input int u);
    int left;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk); #1;
      left = (u == 0) ? exp_q0.size() : exp_q1.size();
      if (left == 0) return;
    end
    left = (u == 0) ? exp_q0.size() : exp_q1.size();
    chk("drain_timeout", left[7:0], 8'd0);
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      tx_start[u] = 1'b0; din[u] = '0; msb_first[u] = 1'b0;
    end
    #3;
    for (int u = 0; u < 2; u++)
      chk("reset outputs", {3'b0, ctrl[u], sout[u], busy[u], done[u]}, 8'b000_00_1_0_0);
    @(posedge clk); #2 reset = 1'b0;

    start_frame(0, 8'hA5, 1'b1, 1, -1); drain(0);
    start_frame(0, 8'hA5, 1'b0, 1, -1); drain(0);
    start_frame(1, 8'h81, 1'b1, 4, -1); drain(1);
    start_frame(1, 8'h5C, 1'b0, 4, -1); drain(1);

    // Mid-frame new request and din change must be ignored.
    start_frame(0, 8'hA5, 1'b1, 1, -1);
    repeat (4) @(posedge clk);
    #2 din[0] = 8'h00; tx_start[0] = 1'b1;
    @(posedge clk); #2 tx_start[0] = 1'b0;
    drain(0);

    // Reset while bit 4 is on the line.
    start_frame(0, 8'hA5, 1'b1, 1, 6);
    drain(0);
    reset = 1'b1;
    #1;
    chk("reset mid-frame ctrl", {6'b0, ctrl[0]}, 8'd0);
    chk("reset mid-frame sout", {7'b0, sout[0]}, 8'd1);
    chk("reset mid-frame busy", {7'b0, busy[0]}, 8'd0);
    chk("reset mid-frame done", {7'b0, done[0]}, 8'd0);
    @(posedge clk); #2 reset = 1'b0;
    for (int k = 0; k < 3; k++) push(0, '{2'b00, 1'b1, 1'b0, 1'b0});
    drain(0);
    start_frame(0, 8'hA5, 1'b1, 1, -1); drain(0);

    start_frame(0, 8'h07, 1'b1, 1, -1); drain(0);
    start_frame(0, 8'h03, 1'b0, 1, -1); drain(0);
    start_frame(0, N'($urandom), 1'b1, 1, -1); drain(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
